// File: rtl/zynq_mmio_responder.sv
// zynq_mmio_responder: AXI4 register endpoint for the Zynq PS GP master, NREGS x 32-bit regs with per-register write pulses; ZYNQ_MMIO_DECERR_EN enables DECERR on out-of-range beats
module zynq_mmio_responder #(
   parameter int          NREGS     = 16,
   parameter int          ADDR_BITS = 12,
   parameter logic [31:0] BASE_ADDR = 32'h43C0_0000
) (
   input  logic                  clock,
   input  logic                  reset_n,
   input  logic                  io_ctrl_aw_valid,
   output logic                  io_ctrl_aw_ready,
   input  logic [31:0]           io_ctrl_aw_bits_addr,
   input  logic [11:0]           io_ctrl_aw_bits_id,
   input  logic [7:0]            io_ctrl_aw_bits_len,
   input  logic [2:0]            io_ctrl_aw_bits_size,
   input  logic [1:0]            io_ctrl_aw_bits_burst,
   input  logic                  io_ctrl_w_valid,
   output logic                  io_ctrl_w_ready,
   input  logic [31:0]           io_ctrl_w_bits_data,
   input  logic [3:0]            io_ctrl_w_bits_strb,
   input  logic                  io_ctrl_w_bits_last,
   output logic                  io_ctrl_b_valid,
   input  logic                  io_ctrl_b_ready,
   output logic [11:0]           io_ctrl_b_bits_id,
   output logic [1:0]            io_ctrl_b_bits_resp,
   input  logic                  io_ctrl_ar_valid,
   output logic                  io_ctrl_ar_ready,
   input  logic [31:0]           io_ctrl_ar_bits_addr,
   input  logic [11:0]           io_ctrl_ar_bits_id,
   input  logic [7:0]            io_ctrl_ar_bits_len,
   input  logic [2:0]            io_ctrl_ar_bits_size,
   input  logic [1:0]            io_ctrl_ar_bits_burst,
   output logic                  io_ctrl_r_valid,
   input  logic                  io_ctrl_r_ready,
   output logic [31:0]           io_ctrl_r_bits_data,
   output logic [11:0]           io_ctrl_r_bits_id,
   output logic [1:0]            io_ctrl_r_bits_resp,
   output logic                  io_ctrl_r_bits_last,
   output logic [32*NREGS-1:0]   io_regs,
   output logic [NREGS-1:0]      io_wr_pulse
);
   localparam int IW = ADDR_BITS - 1;
`ifdef ZYNQ_MMIO_DECERR_EN
   localparam logic DECERR = 1'b1;
`else
   localparam logic DECERR = 1'b0;
`endif
   typedef enum logic [1:0] {IDLE, WDATA, WRESP, RDATA} state_t;
   state_t state_q, state_d;
   logic alive_q;
   logic [11:0] id_q, id_d;
   logic [IW-1:0] idx_q, idx_d, rsel_idx;
   logic hit_q, hit_d, fixed_q, fixed_d, err_q, err_d, roor_q, roor_d, rlast_q, rlast_d;
   logic [7:0] len_q, len_d, cnt_q, cnt_d;
   logic [31:0] rdata_q, rdata_d, rword;
   logic [32*NREGS-1:0] regs_q, regs_d;
   logic [NREGS-1:0] pulse_q, pulse_d;
   logic aw_hs, w_hs, ar_hs, r_hs, rhit, r_ok, w_ok;
   logic unused;
   function automatic logic in_win(input logic [31:0] a);
      return a[31:ADDR_BITS] == BASE_ADDR[31:ADDR_BITS];
   endfunction
   assign unused = ^{io_ctrl_aw_bits_len, io_ctrl_aw_bits_size, io_ctrl_ar_bits_size, io_ctrl_aw_bits_addr[1:0], io_ctrl_ar_bits_addr[1:0]};
   assign aw_hs = io_ctrl_aw_valid & io_ctrl_aw_ready;
   assign w_hs  = io_ctrl_w_valid & io_ctrl_w_ready;
   assign ar_hs = io_ctrl_ar_valid & io_ctrl_ar_ready;
   assign r_hs  = io_ctrl_r_valid & io_ctrl_r_ready;
   // alive_q keeps the ready outputs low until the first edge after reset release
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         alive_q <= 1'b0;
      end else begin
         state_q <= state_d;
         alive_q <= 1'b1;
      end
   end
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:  state_d = aw_hs ? WDATA : ar_hs ? RDATA : IDLE;
         WDATA: state_d = (w_hs && io_ctrl_w_bits_last) ? WRESP : WDATA;
         WRESP: state_d = io_ctrl_b_ready ? IDLE : WRESP;
         RDATA: state_d = (r_hs && rlast_q) ? IDLE : RDATA;
         default: state_d = IDLE;
      endcase
   end
   // write wins a same-cycle AW/AR collision
   always_comb begin
      io_ctrl_aw_ready = alive_q && state_q == IDLE;
      io_ctrl_ar_ready = alive_q && state_q == IDLE && !io_ctrl_aw_valid;
      io_ctrl_w_ready  = state_q == WDATA;
      io_ctrl_b_valid  = state_q == WRESP;
      io_ctrl_r_valid  = state_q == RDATA;
   end
   assign io_ctrl_b_bits_id   = id_q;
   assign io_ctrl_b_bits_resp = {2{err_q & DECERR}};
   assign io_ctrl_r_bits_id   = id_q;
   assign io_ctrl_r_bits_data = rdata_q;
   assign io_ctrl_r_bits_resp = {2{roor_q & DECERR}};
   assign io_ctrl_r_bits_last = rlast_q;
   assign io_regs     = regs_q;
   assign io_wr_pulse = pulse_q;
   // read beat to load next: the AR address on accept, otherwise the following beat
   assign rsel_idx = ar_hs ? {1'b0, io_ctrl_ar_bits_addr[ADDR_BITS-1:2]} : fixed_q ? idx_q : idx_q + IW'(1);
   assign rhit = ar_hs ? in_win(io_ctrl_ar_bits_addr) : hit_q;
   assign r_ok = rhit && 32'(rsel_idx) < 32'(NREGS);
   assign w_ok = hit_q && 32'(idx_q) < 32'(NREGS);
   always_comb begin
      rword = '0;
      for (int i = 0; i < NREGS; i++) if (rsel_idx == IW'(i)) rword = regs_q[32*i +: 32];
   end
   always_comb begin
      id_d = id_q;
      idx_d = idx_q;
      hit_d = hit_q;
      fixed_d = fixed_q;
      err_d = err_q;
      len_d = len_q;
      cnt_d = cnt_q;
      rdata_d = rdata_q;
      roor_d = roor_q;
      rlast_d = rlast_q;
      regs_d = regs_q;
      pulse_d = '0;
      if (aw_hs) begin
         id_d = io_ctrl_aw_bits_id;
         idx_d = {1'b0, io_ctrl_aw_bits_addr[ADDR_BITS-1:2]};
         hit_d = in_win(io_ctrl_aw_bits_addr);
         fixed_d = io_ctrl_aw_bits_burst == 2'b00;
         err_d = 1'b0;
      end
      if (w_hs) begin
         idx_d = fixed_q ? idx_q : idx_q + IW'(1);
         err_d = err_q | !w_ok;
         for (int i = 0; i < NREGS; i++) begin
            if (w_ok && idx_q == IW'(i)) begin
               pulse_d[i] = 1'b1;
               for (int b = 0; b < 4; b++) if (io_ctrl_w_bits_strb[b]) regs_d[32*i+8*b +: 8] = io_ctrl_w_bits_data[8*b +: 8];
            end
         end
      end
      if (ar_hs) begin
         id_d = io_ctrl_ar_bits_id;
         len_d = io_ctrl_ar_bits_len;
         fixed_d = io_ctrl_ar_bits_burst == 2'b00;
      end
      if (ar_hs || (r_hs && !rlast_q)) begin
         idx_d = rsel_idx;
         hit_d = rhit;
         rdata_d = r_ok ? rword : 32'h0;
         roor_d = !r_ok;
         cnt_d = ar_hs ? 8'd0 : cnt_q + 8'd1;
         rlast_d = cnt_d == (ar_hs ? io_ctrl_ar_bits_len : len_q);
      end
   end
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         id_q <= '0;
         idx_q <= '0;
         hit_q <= 1'b0;
         fixed_q <= 1'b0;
         err_q <= 1'b0;
         len_q <= '0;
         cnt_q <= '0;
         rdata_q <= '0;
         roor_q <= 1'b0;
         rlast_q <= 1'b0;
         regs_q <= '0;
         pulse_q <= '0;
      end else begin
         id_q <= id_d;
         idx_q <= idx_d;
         hit_q <= hit_d;
         fixed_q <= fixed_d;
         err_q <= err_d;
         len_q <= len_d;
         cnt_q <= cnt_d;
         rdata_q <= rdata_d;
         roor_q <= roor_d;
         rlast_q <= rlast_d;
         regs_q <= regs_d;
         pulse_q <= pulse_d;
      end
   end
endmodule
